// File: rtl/store_rmw_unit_pkg.sv
// Shared types for the store read-modify-write path:
// FSM encoding, store size codes and byte-lane numbers.
package store_rmw_unit_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WAIT  = 2'd2,
        WRITE = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        SZ_NONE = 2'd0,
        SZ_B    = 2'd1,
        SZ_H    = 2'd2,
        SZ_W    = 2'd3
    } size_t;

    localparam logic [1:0] LANE0 = 2'd0;
    localparam logic [1:0] LANE1 = 2'd1;
    localparam logic [1:0] LANE2 = 2'd2;
    localparam logic [1:0] LANE3 = 2'd3;

    // Word wins over halfword, halfword over byte.
    function automatic size_t size_decode(
        input logic sb,
        input logic sh,
        input logic sw
    );
        if (sw)      return SZ_W;
        else if (sh) return SZ_H;
        else if (sb) return SZ_B;
        else         return SZ_NONE;
    endfunction

endpackage

// File: rtl/store_rmw_unit_lane_merge.sv
// Little-endian byte/halfword merge into an old DMEM word,
// plus alignment check for the requested size.
module store_lane_merge
    import store_rmw_unit_pkg::*;
(
    input  logic [31:0] old_word,
    input  logic [31:0] wdata,
    input  logic [1:0]  size,
    input  logic [1:0]  lane,
    output logic [31:0] merged,
    output logic        misalign
);

    always_comb begin
        merged   = old_word;
        misalign = 1'b0;
        case (size)
            SZ_B: begin
                case (lane)
                    LANE0: merged[7:0]   = wdata[7:0];
                    LANE1: merged[15:8]  = wdata[7:0];
                    LANE2: merged[23:16] = wdata[7:0];
                    LANE3: merged[31:24] = wdata[7:0];
                    default: ;
                endcase
            end
            SZ_H: begin
                if (lane[0])
                    misalign = 1'b1;
                else if (lane[1])
                    merged[31:16] = wdata[15:0];
                else
                    merged[15:0] = wdata[15:0];
            end
            SZ_W: begin
                merged   = wdata;
                misalign = (lane != LANE0);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/store_rmw_unit.sv
// Store unit: full-word stores write directly, sub-word stores
// read the DMEM word, merge, and write it back in one WRITE cycle.
module store_rmw_unit
    import store_rmw_unit_pkg::*;
#(
    parameter int ADDR_W   = 11,
    parameter int READ_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    input  logic              SbEn,
    input  logic              ShEn,
    input  logic              SwEn,
    output logic              done,
    output logic              misalign,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    output logic              mem_we,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam int CNT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(READ_LAT - 1);

    state_t            state;
    state_t            state_nx;
    logic [ADDR_W+1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rdata_q;
    logic [1:0]        size_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              done_q;
    logic              mis_q;

    size_t       req_size;
    logic        accept;
    logic        mis_now;
    logic [1:0]  sel_size;
    logic [1:0]  sel_lane;
    logic [31:0] sel_wdata;
    logic [31:0] merged;
    logic        unused_addr;

    assign unused_addr = ^addr[31:ADDR_W+2];
    assign req_size    = size_decode(SbEn, ShEn, SwEn);
    assign accept      = req_valid && (state == IDLE);

    // While idle the merger checks alignment of the incoming request;
    // afterwards it works on the latched request.
    assign sel_size  = (state == IDLE) ? req_size   : size_q;
    assign sel_lane  = (state == IDLE) ? addr[1:0]  : addr_q[1:0];
    assign sel_wdata = (state == IDLE) ? wdata      : wdata_q;

    store_lane_merge u_merge (
        .old_word (rdata_q),
        .wdata    (sel_wdata),
        .size     (sel_size),
        .lane     (sel_lane),
        .merged   (merged),
        .misalign (mis_now)
    );

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (accept && !mis_now) begin
                    if (req_size == SZ_W)
                        state_nx = WRITE;
                    else if (req_size != SZ_NONE)
                        state_nx = READ;
                end
            end
            READ:  state_nx = WAIT;
            WAIT:  if (cnt_q == LAST) state_nx = WRITE;
            WRITE: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            size_q  <= SZ_NONE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            state  <= state_nx;
            done_q <= accept && (req_size == SZ_NONE || mis_now);
            mis_q  <= accept && mis_now;
            if (accept) begin
                addr_q  <= addr[ADDR_W+1:0];
                wdata_q <= wdata;
                size_q  <= req_size;
            end
            if (state == READ)
                cnt_q <= '0;
            else if (state == WAIT)
                cnt_q <= cnt_q + 1'b1;
            if (state == WAIT && cnt_q == LAST)
                rdata_q <= mem_rdata;
        end
    end

    assign req_ready = (state == IDLE);
    assign mem_re    = (state == READ);
    assign mem_we    = (state == WRITE);
    assign mem_addr  = addr_q[ADDR_W+1:2];
    assign mem_wdata = mem_we ? merged : 32'h0;
    assign done      = done_q | mem_we;
    assign misalign  = mis_q;

endmodule

// File: tb/tb_store_rmw_unit.sv
// Directed bench for store_rmw_unit: one DUT at READ_LAT=1,
// a second at READ_LAT=3, each with a latency-accurate DMEM model.
module tb_store_rmw_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        sb = 1'b0, sh = 1'b0, sw = 1'b0;
    logic        v1 = 1'b0, v2 = 1'b0;

    logic        ready1, done1, mis1, re1, we1;
    logic [10:0] maddr1;
    logic [31:0] mwd1, mrd1;
    logic        ready2, done2, mis2, re2, we2;
    logic [10:0] maddr2;
    logic [31:0] mwd2, mrd2;

    logic [31:0] rd_word1 = 32'h0;
    logic [31:0] rd_word2 = 32'h0;
    logic        re1_d = 1'b0;
    logic [2:0]  re2_sh = 3'b0;

    int tests = 0;
    int fails = 0;
    int done1_n = 0, done2_n = 0;
    int re1_n = 0, we1_n = 0;
    int both_n = 0;

    always #5 clk = ~clk;

    store_rmw_unit #(.ADDR_W(11), .READ_LAT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .req_valid(v1), .req_ready(ready1),
        .addr(addr), .wdata(wdata), .SbEn(sb), .ShEn(sh), .SwEn(sw),
        .done(done1), .misalign(mis1), .mem_addr(maddr1),
        .mem_re(re1), .mem_we(we1), .mem_wdata(mwd1), .mem_rdata(mrd1)
    );

    store_rmw_unit #(.ADDR_W(11), .READ_LAT(3)) dut2 (
        .clk(clk), .rst_n(rst_n), .req_valid(v2), .req_ready(ready2),
        .addr(addr), .wdata(wdata), .SbEn(sb), .ShEn(sh), .SwEn(sw),
        .done(done2), .misalign(mis2), .mem_addr(maddr2),
        .mem_re(re2), .mem_we(we2), .mem_wdata(mwd2), .mem_rdata(mrd2)
    );

    // Read data is valid only READ_LAT cycles after mem_re; garbage otherwise.
    always @(posedge clk) begin
        re1_d  <= re1;
        re2_sh <= {re2_sh[1:0], re2};
        if (done1) done1_n++;
        if (done2) done2_n++;
        if (re1) re1_n++;
        if (we1) we1_n++;
        if ((re1 && we1) || (re2 && we2)) both_n++;
    end
    assign mrd1 = re1_d     ? rd_word1 : 32'hBAD0BAD0;
    assign mrd2 = re2_sh[2] ? rd_word2 : 32'hBAD0BAD0;

    task automatic start1(input logic [31:0] a, input logic [31:0] d,
                          input logic b, input logic h, input logic w);
        @(negedge clk);
        addr = a; wdata = d; sb = b; sh = h; sw = w; v1 = 1'b1;
        @(negedge clk);
        v1 = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; v1 = 1'b0; v2 = 1'b0;
        repeat (2) @(negedge clk);
        tests++;
        if ({ready1, done1, mis1, re1, we1} !== 5'b10000) begin
            fails++;
            $display("FAIL reset_ctl got=%b want=10000",
                     {ready1, done1, mis1, re1, we1});
        end
        tests++;
        if (maddr1 !== 11'd0 || mwd1 !== 32'h0) begin
            fails++;
            $display("FAIL reset_bus addr=%h wdata=%h want 0/0", maddr1, mwd1);
        end
        tests++;
        if ({ready2, done2, re2, we2} !== 4'b1000) begin
            fails++;
            $display("FAIL reset_dut2 got=%b want=1000",
                     {ready2, done2, re2, we2});
        end
        rst_n = 1'b1;
    endtask

    task automatic test_sw;
        start1(32'h10, 32'hDEADBEEF, 1'b0, 1'b0, 1'b1);
        tests++;
        if ({we1, re1, done1, mis1, ready1} !== 5'b10100 || maddr1 !== 11'd4
            || mwd1 !== 32'hDEADBEEF) begin
            fails++;
            $display("FAIL sw_t1 ctl=%b addr=%h wd=%h want 10100/4/deadbeef",
                     {we1, re1, done1, mis1, ready1}, maddr1, mwd1);
        end
        @(negedge clk);
        tests++;
        if ({ready1, done1, we1} !== 3'b100) begin
            fails++;
            $display("FAIL sw_t2 got=%b want=100", {ready1, done1, we1});
        end
    endtask

    task automatic test_sb;
        rd_word1 = 32'h11223344;
        start1(32'h13, 32'h000000AA, 1'b1, 1'b0, 1'b0);
        tests++;
        if ({re1, we1, done1, ready1} !== 4'b1000 || maddr1 !== 11'd4) begin
            fails++;
            $display("FAIL sb_t1 ctl=%b addr=%h want 1000/4",
                     {re1, we1, done1, ready1}, maddr1);
        end
        @(negedge clk);
        tests++;
        if ({re1, we1, done1, ready1} !== 4'b0000) begin
            fails++;
            $display("FAIL sb_t2 got=%b want=0000", {re1, we1, done1, ready1});
        end
        @(negedge clk);
        tests++;
        if ({we1, done1, re1} !== 3'b110 || mwd1 !== 32'hAA223344) begin
            fails++;
            $display("FAIL sb_t3 ctl=%b wd=%h want 110/aa223344",
                     {we1, done1, re1}, mwd1);
        end
        @(negedge clk);
        tests++;
        if ({ready1, done1} !== 2'b10) begin
            fails++;
            $display("FAIL sb_t4 got=%b want=10", {ready1, done1});
        end
    endtask

    task automatic test_sh;
        logic [31:0] a_tab [2] = '{32'h22, 32'h20};
        logic [31:0] e_tab [2] = '{32'hBEEF3344, 32'h1122BEEF};
        rd_word1 = 32'h11223344;
        for (int i = 0; i < 2; i++) begin
            start1(a_tab[i], 32'h0000BEEF, 1'b0, 1'b1, 1'b0);
            repeat (2) @(negedge clk);
            tests++;
            if (we1 !== 1'b1 || done1 !== 1'b1 || maddr1 !== 11'd8
                || mwd1 !== e_tab[i]) begin
                fails++;
                $display("FAIL sh_%0d we=%b done=%b addr=%h wd=%h want 1/1/8/%h",
                         i, we1, done1, maddr1, mwd1, e_tab[i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_nop;
        int r0 = re1_n;
        int w0 = we1_n;
        start1(32'h10, 32'h12345678, 1'b0, 1'b0, 1'b0);
        tests++;
        if ({done1, mis1, re1, we1} !== 4'b1000) begin
            fails++;
            $display("FAIL nop_t1 got=%b want=1000", {done1, mis1, re1, we1});
        end
        @(negedge clk);
        tests++;
        if (done1 !== 1'b0 || re1_n != r0 || we1_n != w0) begin
            fails++;
            $display("FAIL nop_t2 done=%b reads=%0d writes=%0d want 0/0/0",
                     done1, re1_n - r0, we1_n - w0);
        end
    endtask

    task automatic test_misalign;
        logic [31:0] a_tab [3] = '{32'h21, 32'h22, 32'h01};
        logic [2:0]  e_tab [3] = '{3'b010, 3'b001, 3'b011};
        int r0 = re1_n;
        int w0 = we1_n;
        for (int i = 0; i < 3; i++) begin
            start1(a_tab[i], 32'hFFFF_FFFF, e_tab[i][2], e_tab[i][1],
                   e_tab[i][0]);
            tests++;
            if ({done1, mis1, re1, we1} !== 4'b1100) begin
                fails++;
                $display("FAIL mis_%0d t1 got=%b want=1100",
                         i, {done1, mis1, re1, we1});
            end
            @(negedge clk);
            tests++;
            if ({done1, mis1} !== 2'b00) begin
                fails++;
                $display("FAIL mis_%0d t2 got=%b want=00", i, {done1, mis1});
            end
        end
        tests++;
        if (re1_n != r0 || we1_n != w0) begin
            fails++;
            $display("FAIL mis_noaccess reads=%0d writes=%0d want 0/0",
                     re1_n - r0, we1_n - w0);
        end
    endtask

    task automatic test_priority;
        start1(32'h10, 32'hCAFEF00D, 1'b1, 1'b1, 1'b1);
        tests++;
        if ({we1, re1, done1} !== 3'b101 || mwd1 !== 32'hCAFEF00D) begin
            fails++;
            $display("FAIL prio ctl=%b wd=%h want 101/cafef00d",
                     {we1, re1, done1}, mwd1);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        int w0 = we1_n;
        rd_word1 = 32'h11223344;
        start1(32'h13, 32'h000000AA, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        tests++;
        if ({ready1, we1, done1} !== 3'b100 || maddr1 !== 11'd0) begin
            fails++;
            $display("FAIL rstmid ctl=%b addr=%h want 100/0",
                     {ready1, we1, done1}, maddr1);
        end
        rst_n = 1'b1;
        @(negedge clk);
        tests++;
        if (we1_n != w0) begin
            fails++;
            $display("FAIL rstmid_nowrite writes=%0d want 0", we1_n - w0);
        end
        start1(32'h14, 32'h0BADF00D, 1'b0, 1'b0, 1'b1);
        tests++;
        if ({we1, done1} !== 2'b11 || maddr1 !== 11'd5
            || mwd1 !== 32'h0BADF00D) begin
            fails++;
            $display("FAIL rstmid_sw ctl=%b addr=%h wd=%h want 11/5/0badf00d",
                     {we1, done1}, maddr1, mwd1);
        end
        @(negedge clk);
    endtask

    task automatic test_lat3;
        int d0 = done2_n;
        rd_word2 = 32'h11223344;
        @(negedge clk);
        addr = 32'h01; wdata = 32'h00000055;
        sb = 1'b1; sh = 1'b0; sw = 1'b0; v2 = 1'b1;
        @(negedge clk);
        v2 = 1'b0;
        tests++;
        if ({re2, we2, ready2} !== 3'b100) begin
            fails++;
            $display("FAIL lat3_t1 got=%b want=100", {re2, we2, ready2});
        end
        for (int c = 2; c <= 4; c++) begin
            @(negedge clk);
            tests++;
            if ({re2, we2, done2, ready2} !== 4'b0000) begin
                fails++;
                $display("FAIL lat3_wait%0d got=%b want=0000",
                         c, {re2, we2, done2, ready2});
            end
            // Competing word store while busy must be ignored.
            v2 = (c < 4);
            addr = 32'h10; wdata = 32'hFFFFFFFF; sw = 1'b1;
        end
        v2 = 1'b0;
        @(negedge clk);
        tests++;
        if ({we2, done2} !== 2'b11 || maddr2 !== 11'd0
            || mwd2 !== 32'h11225544) begin
            fails++;
            $display("FAIL lat3_write ctl=%b addr=%h wd=%h want 11/0/11225544",
                     {we2, done2}, maddr2, mwd2);
        end
        @(negedge clk);
        tests++;
        if (ready2 !== 1'b1 || done2_n - d0 != 1) begin
            fails++;
            $display("FAIL lat3_end ready=%b dones=%0d want 1/1",
                     ready2, done2_n - d0);
        end
    endtask

    initial begin
        test_reset();
        test_sw();
        test_sb();
        test_sh();
        test_nop();
        test_misalign();
        test_priority();
        test_reset_mid();
        test_lat3();
        tests++;
        if (both_n != 0) begin
            fails++;
            $display("FAIL re_we_overlap cycles=%0d want 0", both_n);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/store_rmw_unit.md
Name: store_rmw_unit

Overview:
- Store-side companion to the load-extension path. Takes a CPU store request (SB/SH/SW) and writes it into the word-organised, single-port DMEM.
- Sub-word stores use a read-modify-write sequence: read the word, merge the new byte or halfword, write the word back.
- Sits between the EX/MEM stage and DMEM. Holds the pipeline through `req_ready` while a sequence is in flight.

Parameters:
- ADDR_W, 11, DMEM word-address width; `mem_addr = addr[ADDR_W+1:2]`.
- READ_LAT, 1, cycles from the `mem_re` cycle until `mem_rdata` is valid (>=1).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous reset, active-low
- req_valid  in  1  store request present
- req_ready  out  1  unit idle and able to accept; equals (state==IDLE)
- addr  in  32  byte address of the store
- wdata  in  32  store data; SB uses [7:0], SH uses [15:0]
- SbEn  in  1  store byte
- ShEn  in  1  store halfword
- SwEn  in  1  store word
- done  out  1  one-cycle pulse when the request retires
- misalign  out  1  one-cycle pulse, coincident with `done`, on a misaligned request
- mem_addr  out  ADDR_W  DMEM word address
- mem_re  out  1  DMEM read strobe
- mem_we  out  1  DMEM write strobe, full word
- mem_wdata  out  32  DMEM write data
- mem_rdata  in  32  DMEM read data

Behaviour:
- Reset (rst_n=0 at a clock edge): state=IDLE; `done`, `misalign`, `mem_re`, `mem_we` = 0; `mem_addr` = 0; `mem_wdata` = 0; latched request cleared. `req_ready` = 1 once in IDLE.
- Accept: `req_valid && req_ready` at edge T latches `addr`, `wdata` and the size.
- Size priority: SwEn > ShEn > SbEn.
- No enable set: NOP. `done` at T+1, no memory access.
- States: IDLE, READ, WAIT, WRITE.
- SW path (aligned): IDLE -> WRITE.
  - In WRITE at T+1: `mem_we`=1, `mem_wdata`=wdata, `done`=1.
  - Next state IDLE; `req_ready`=1 at T+2.
- SB/SH path (aligned): IDLE -> READ (T+1, `mem_re`=1) -> WAIT for READ_LAT cycles -> WRITE.
  - WAIT captures `mem_rdata` on its final cycle.
  - In WRITE: `mem_we`=1 with the merged word, `done`=1.
  - With READ_LAT=1: READ T+1, WAIT T+2, WRITE/done T+3, ready T+4.
- `mem_addr` holds the latched word address for the whole sequence.
- Merge is little-endian with lane = addr[1:0].
  - SB: byte[lane] = wdata[7:0]; other bytes keep `mem_rdata`.
  - SH: addr[1]=0 -> [15:0] replaced; addr[1]=1 -> [31:16] replaced.
- Misaligned (SH with addr[0]=1; SW with addr[1:0]!=0):
  - No `mem_re` or `mem_we`.
  - `done`=1 and `misalign`=1 at T+1, then IDLE.
- `req_valid` while busy is ignored; the requester must hold it until `req_ready`.
- Reset mid-sequence: immediate return to IDLE, no write issued.
  - Because `mem_we` is asserted only in the single WRITE cycle, DMEM never sees a partial update.
- `mem_re` and `mem_we` are never both 1. `done` is exactly one pulse per accepted request.

Decomposition:
- Shared package holds:
  - State encoding: IDLE=2'd0, READ=2'd1, WAIT=2'd2, WRITE=2'd3.
  - Size codes: SZ_NONE, SZ_B, SZ_H, SZ_W.
  - Byte-lane constants.
- One combinational sub-module, `store_lane_merge`: inputs old word, wdata, size, lane; outputs merged word and misalign flag.
- The FSM, WAIT counter and request latches stay in `store_rmw_unit`.

Test Plan:
- SW addr=0x10, wdata=0xDEADBEEF -> T+1: mem_we=1, mem_addr=4, mem_wdata=0xDEADBEEF, done=1; ready at T+2.
- SB addr=0x13, wdata=0x000000AA, mem_rdata=0x11223344 -> mem_re at T+1; T+3: mem_we=1, mem_wdata=0xAA223344, done=1.
- SH addr=0x22, wdata=0x0000BEEF, mem_rdata=0x11223344 -> mem_wdata=0xBEEF3344; SH addr=0x20 -> 0x1122BEEF.
- SH addr=0x21 and SW addr=0x22 -> done=1 and misalign=1 at T+1; mem_re=mem_we=0 throughout.
- SB accepted, rst_n=0 during WAIT -> next cycle state IDLE, mem_we never 1, req_ready=1; a following SW completes normally.
- READ_LAT=3, SB addr=0x01 -> WRITE at T+5, merged byte in lane 1; req_valid pulses while busy produce no extra `done`.
